full_mem_data_banked: RTL and testbench
=======================================

Name: full_mem_data_banked

Overview:
Parametrised successor to the single-bank 32x64 memory data wrapper. Provides one write port and one read port over NUM_BANKS address-interleaved 1R1W banks, with configurable read latency and write-first bypass on same-address collisions. Adds a hardware initialisation/clear sequencer so contents are defined after reset and on demand. Sits between a layer datapath and its weight/activation storage in the full design.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 64, total words; power of 2; at least NUM_BANKS
NUM_BANKS, 2, interleave factor; power of 2; bank = addr[log2(NUM_BANKS)-1:0]
RD_LAT, 1, read latency in cycles from accepted read to rd_data_valid; legal values 1 or 2
INIT_VALUE, 0, WIDTH-bit value written to every word during init/clear

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
clear  input  1  single-cycle pulse; re-runs the init sequence
wr_valid  input  1  write request
wr_ready  output  1  write accepted when wr_valid && wr_ready
wr_addr  input  log2(DEPTH)  write word address
wr_data  input  WIDTH  write data
rd_valid  input  1  read request
rd_ready  output  1  read accepted when rd_valid && rd_ready
rd_addr  input  log2(DEPTH)  read word address
rd_data  output  WIDTH  read data, qualified by rd_data_valid
rd_data_valid  output  1  rd_data holds the result of a read accepted RD_LAT cycles earlier
init_done  output  1  high while in RUN

Behaviour:
- Reset (reset=0, asynchronous): state=INIT, init_cnt=0, rd_data=0, rd_data_valid=0, read pipeline valids=0, init_done=0, wr_ready=rd_ready=0. Memory array is not reset.
- FSM states: INIT, RUN.
- INIT: each cycle writes INIT_VALUE to row init_cnt of every bank in parallel; init_cnt increments. When init_cnt = DEPTH/NUM_BANKS-1, transition to RUN on the next edge (INIT lasts DEPTH/NUM_BANKS cycles). wr_ready=rd_ready=0. Requests are ignored, not queued.
- RUN: init_done=1. wr_ready = rd_ready = !clear (combinational).
- clear=1 in RUN: next state INIT, init_cnt=0. Any write or read presented that cycle is not accepted. clear in INIT restarts init_cnt at 0.
- Write: on accept, bank[wr_addr mod NUM_BANKS] row wr_addr/NUM_BANKS <= wr_data at that edge.
- Read: on accept, rd_data_valid=1 exactly RD_LAT cycles later, with data of that address. One read per cycle; full throughput; no bank conflicts, because each bank is 1R1W.
- Collision: write and read accepted the same cycle to the same address returns the new wr_data (write-first). Different addresses are independent.
- RD_LAT=1: bank read register drives rd_data. RD_LAT=2: an additional output register stage is added. Bypass data follows the same pipeline.
- rd_data holds its last value when rd_data_valid=0.
- Reads already in the pipeline when clear is accepted still complete with pre-clear data.
- Reset mid-operation: pipeline is flushed immediately, with no spurious rd_data_valid after reset release.
- Address arithmetic: the bank select uses the low log2(NUM_BANKS) bits; the row uses the remaining high bits. There are no out-of-range addresses because DEPTH is a power of 2.

Decomposition:
- Shared package full_mem_pkg:
  - state enum {INIT, RUN}
  - clog2-based width constants (AW, BW, ROW_W)
  - the default INIT_VALUE
- Sub-module full_mem_bank:
  - one 1R1W bank, DEPTH/NUM_BANKS x WIDTH, registered read, write-first bypass
  - instantiated NUM_BANKS times by generate
- The top holds:
  - FSM and init counter
  - bank decode and write-enable fan-out
  - bank-select pipeline for the read mux
  - optional output stage

Test Plan:
- Defaults. Release reset, hold requests: init_done rises after exactly 32 cycles; wr_ready/rd_ready=0 throughout INIT. Then read addr 0..63 -> all 0x00000000.
- Write 0xDEADBEEF @5 and 0x12345678 @6. Read 5 then 6 back-to-back -> rd_data_valid on consecutive cycles, 1 cycle after each accept, data 0xDEADBEEF then 0x12345678.
- Same-cycle write 0xA5A5A5A5 @9 and read @9 (old value 0) -> returns 0xA5A5A5A5. Repeat with RD_LAT=2 -> same data 2 cycles after accept.
- Stream reads @0..7, one per cycle, after writing addr=value -> 8 contiguous rd_data_valid cycles, data 0..7, alternating banks, no bubbles.
- Write 0xFFFFFFFF @3. Pulse clear while presenting write @4 and read @3 -> neither accepted, init_done=0 for 32 cycles. Read @3 and @4 -> 0.
- Assert reset 10 cycles into INIT, and separately with a read in flight -> outputs return to 0 immediately, no rd_data_valid after release, full 32-cycle INIT restarts.

Source files
------------

// File: rtl/full_mem_pkg.sv
// Shared types and default geometry for the banked memory data wrapper.
package full_mem_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_NUM_BANKS = 2;

  localparam int AW    = $clog2(DEF_DEPTH);
  localparam int BW    = $clog2(DEF_NUM_BANKS);
  localparam int ROW_W = AW - BW;

  localparam logic [DEF_WIDTH-1:0] DEF_INIT_VALUE = '0;

endpackage

// File: rtl/full_mem_bank.sv
// One 1R1W storage bank with a registered read port and write-first bypass.
module full_mem_bank #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [RW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [RW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register only moves on a read, so it holds the last result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rdata <= '0;
    else if (re)
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/full_mem_data_banked.sv
// Address-interleaved 1W1R memory with init/clear sequencer and 1- or 2-cycle reads.
module full_mem_data_banked
  import full_mem_pkg::*;
#(
  parameter int                WIDTH      = DEF_WIDTH,
  parameter int                DEPTH      = DEF_DEPTH,
  parameter int                NUM_BANKS  = DEF_NUM_BANKS,
  parameter int                RD_LAT     = 1,
  parameter logic [WIDTH-1:0]  INIT_VALUE = WIDTH'(DEF_INIT_VALUE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_data_valid,
  output logic                     init_done
);

  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int BANK_W   = $clog2(NUM_BANKS);
  localparam int ROWS     = DEPTH / NUM_BANKS;
  localparam int ROW_BITS = ADDR_W - BANK_W;

  state_t              state;
  logic [ROW_BITS-1:0] init_cnt;
  logic                in_init;
  logic                wr_acc;
  logic                rd_acc;
  logic [BANK_W-1:0]   wr_bank;
  logic [BANK_W-1:0]   rd_bank;
  logic [ROW_BITS-1:0] wr_row;
  logic [ROW_BITS-1:0] rd_row;
  logic [ROW_BITS-1:0] bank_waddr;
  logic [WIDTH-1:0]    bank_wdata;
  logic [WIDTH-1:0]    bank_rdata [NUM_BANKS];
  logic [BANK_W-1:0]   sel_q;
  logic                v1_q;
  logic [WIDTH-1:0]    bank_out;

  assign in_init   = (state == INIT);
  assign init_done = (state == RUN);
  assign wr_ready  = (state == RUN) && !clear;
  assign rd_ready  = (state == RUN) && !clear;
  assign wr_acc    = wr_valid && wr_ready;
  assign rd_acc    = rd_valid && rd_ready;

  assign wr_bank = wr_addr[BANK_W-1:0];
  assign rd_bank = rd_addr[BANK_W-1:0];
  assign wr_row  = wr_addr[ADDR_W-1:BANK_W];
  assign rd_row  = rd_addr[ADDR_W-1:BANK_W];

  // During INIT every bank is written at the same row in parallel.
  assign bank_waddr = in_init ? init_cnt : wr_row;
  assign bank_wdata = in_init ? INIT_VALUE : wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          if (clear)
            init_cnt <= '0;
          else if (init_cnt == ROW_BITS'(ROWS - 1)) begin
            state    <= RUN;
            init_cnt <= '0;
          end else
            init_cnt <= init_cnt + 1'b1;
        end
        RUN: begin
          if (clear) begin
            state    <= INIT;
            init_cnt <= '0;
          end
        end
        default: begin
          state    <= INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_we;
    logic bank_re;
    assign bank_we = in_init || (wr_acc && (wr_bank == BANK_W'(b)));
    assign bank_re = rd_acc && (rd_bank == BANK_W'(b));

    full_mem_bank #(
      .WIDTH (WIDTH),
      .ROWS  (ROWS),
      .RW    (ROW_BITS)
    ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (bank_re),
      .raddr (rd_row),
      .rdata (bank_rdata[b])
    );
  end

  // Bank select travels with the read so the mux picks the right bank register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) sel_q <= rd_bank;
    end
  end

  assign bank_out = bank_rdata[sel_q];

  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] out_q;
    logic             v2_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_q <= '0;
        v2_q  <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) out_q <= bank_out;
      end
    end

    assign rd_data       = out_q;
    assign rd_data_valid = v2_q;
  end else begin : g_lat1
    assign rd_data       = bank_out;
    assign rd_data_valid = v1_q;
  end

endmodule

// File: tb/tb_full_mem_data_banked.sv
// Scoreboard bench driving a 1-cycle and a 2-cycle instance with identical stimulus.
module tb_full_mem_data_banked;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        wr_valid = 1'b0;
  logic        rd_valid = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [5:0]  rd_addr = '0;
  logic [31:0] wr_data = '0;

  logic        wr_ready1, rd_ready1, rd_data_valid1, init_done1;
  logic        wr_ready2, rd_ready2, rd_data_valid2, init_done2;
  logic [31:0] rd_data1, rd_data2;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          run_mode = 1'b0;
  logic [31:0] model_mem [64];
  exp_t        q1 [$];
  exp_t        q2 [$];
  exp_t        e1, e2;

  full_mem_data_banked #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready1), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_data_valid(rd_data_valid1), .init_done(init_done1)
  );

  full_mem_data_banked #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready2), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_data_valid(rd_data_valid2), .init_done(init_done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Pop the scoreboard whenever an instance presents data; catch reads that never arrive.
  always @(negedge clk) begin
    if (reset) begin
      if (rd_data_valid1) begin
        checkOutput("rd1_expected", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          checkOutput("rd1_data", rd_data1, e1.data);
          checkOutput("rd1_cycle", cyc, e1.due);
        end
      end else if (q1.size() != 0 && cyc > q1[0].due) begin
        e1 = q1.pop_front();
        checkOutput("rd1_missing", cyc, e1.due);
      end
      if (rd_data_valid2) begin
        checkOutput("rd2_expected", q2.size() != 0, 1);
        if (q2.size() != 0) begin
          e2 = q2.pop_front();
          checkOutput("rd2_data", rd_data2, e2.data);
          checkOutput("rd2_cycle", cyc, e2.due);
        end
      end else if (q2.size() != 0 && cyc > q2[0].due) begin
        e2 = q2.pop_front();
        checkOutput("rd2_missing", cyc, e2.due);
      end
    end
  end

  task automatic zeroModel();
    foreach (model_mem[i]) model_mem[i] = '0;
  endtask

  task automatic applyStimulus(input bit wv, input logic [5:0] wa, input logic [31:0] wd,
                               input bit rv, input logic [5:0] ra, input bit clr);
    bit   acc;
    exp_t e;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    rd_valid = rv;
    rd_addr  = ra;
    clear    = clr;
    acc      = run_mode && !clr;
    #1;
    checkOutput("wr_ready1", wr_ready1, acc);
    checkOutput("rd_ready1", rd_ready1, acc);
    checkOutput("wr_ready2", wr_ready2, acc);
    checkOutput("rd_ready2", rd_ready2, acc);
    if (wv && acc) model_mem[wa] = wd;
    if (rv && acc) begin
      e.data = model_mem[ra];
      e.due  = cyc + 1;
      q1.push_back(e);
      e.due  = cyc + 2;
      q2.push_back(e);
    end
    if (clr) begin
      run_mode = 1'b0;
      zeroModel();
    end
    @(negedge clk);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 6'd0, 32'd0, 0, 6'd0, 0);
  endtask

  task automatic doReset();
    reset    = 1'b0;
    run_mode = 1'b0;
    q1.delete();
    q2.delete();
    zeroModel();
    #1;
    checkOutput("rst_flags1", {rd_data_valid1, init_done1, wr_ready1, rd_ready1}, 0);
    checkOutput("rst_data1", rd_data1, 0);
    checkOutput("rst_flags2", {rd_data_valid2, init_done2, wr_ready2, rd_ready2}, 0);
    checkOutput("rst_data2", rd_data2, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic waitInit(input string tag);
    int n = 0;
    while (init_done1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 16)
        checkOutput({tag, "_rdy"}, {wr_ready1, rd_ready1, wr_ready2, rd_ready2}, 0);
    end
    checkOutput(tag, n, 32);
    checkOutput({tag, "_dut2"}, init_done2, 1);
    run_mode = (init_done1 === 1'b1);
  endtask

  initial begin
    zeroModel();
    #2;
    doReset();
    waitInit("init_len");

    for (int i = 0; i < 64; i++) applyStimulus(0, 6'd0, 32'd0, 1, 6'(i), 0);
    idle(3);

    applyStimulus(1, 6'd5, 32'hDEADBEEF, 0, 6'd0, 0);
    applyStimulus(1, 6'd6, 32'h12345678, 0, 6'd0, 0);
    applyStimulus(0, 6'd0, 32'd0, 1, 6'd5, 0);
    applyStimulus(0, 6'd0, 32'd0, 1, 6'd6, 0);
    idle(3);

    applyStimulus(1, 6'd9, 32'hA5A5A5A5, 1, 6'd9, 0);
    idle(3);

    for (int i = 0; i < 8; i++) applyStimulus(1, 6'(i), 32'(i), 0, 6'd0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 6'd0, 32'd0, 1, 6'(i), 0);
    idle(3);
    checkOutput("hold1", rd_data1, 32'd7);
    checkOutput("hold2", rd_data2, 32'd7);

    applyStimulus(1, 6'd3, 32'hFFFFFFFF, 0, 6'd0, 0);
    applyStimulus(0, 6'd0, 32'd0, 1, 6'd3, 0);
    applyStimulus(1, 6'd4, 32'h44444444, 1, 6'd3, 1);
    checkOutput("clr_init_done1", init_done1, 0);
    waitInit("clear_len");
    applyStimulus(0, 6'd0, 32'd0, 1, 6'd3, 0);
    applyStimulus(0, 6'd0, 32'd0, 1, 6'd4, 0);
    idle(3);

    doReset();
    repeat (10) @(negedge clk);
    doReset();
    waitInit("midinit_len");

    applyStimulus(1, 6'd2, 32'h55555555, 0, 6'd0, 0);
    applyStimulus(0, 6'd0, 32'd0, 1, 6'd2, 0);
    #2;
    doReset();
    waitInit("inflight_len");
    idle(4);

    checkOutput("q1_drained", q1.size(), 0);
    checkOutput("q2_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
